// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: default widths,
// control-word bit layout and per-stage payload widths, so every stage
// instance agrees on where each control field lives.
package pipe_pkg;

   // Default widths of a generic pipe_stage_reg instance
   localparam int unsigned DEF_DATA_W = 160;
   localparam int unsigned DEF_CTRL_W = 32;
   localparam int unsigned DEF_CNT_W  = 16;

   // Control-word bit positions (a bubble is the all-zero control word)
   localparam int unsigned CTRL_REG_WE    = 0;   // register-file write
   localparam int unsigned CTRL_MEM_WE    = 1;   // data-memory write
   localparam int unsigned CTRL_MEM_RD    = 2;   // data-memory read
   localparam int unsigned CTRL_JAL       = 3;   // link write of PC+4
   localparam int unsigned CTRL_SYSCALL   = 4;   // environment call
   localparam int unsigned CTRL_BRANCH_EQ = 5;   // conditional branch, equal
   localparam int unsigned CTRL_BRANCH_NE = 6;   // conditional branch, not equal
   localparam int unsigned CTRL_JUMP      = 7;   // unconditional direct jump
   localparam int unsigned CTRL_JUMP_REG  = 8;   // register-indirect jump
   localparam int unsigned CTRL_USED_BITS = 9;

   // Per-stage payload widths
   localparam int unsigned IF_ID_DATA_W  = 64;   // instruction + PC+4
   localparam int unsigned IF_ID_CTRL_W  = 32;
   localparam int unsigned ID_EX_DATA_W  = 160;  // PC+4, rs, rt, imm, instr
   localparam int unsigned ID_EX_CTRL_W  = 32;
   localparam int unsigned EX_MEM_DATA_W = 101;  // alu result, store data, PC+4, rd
   localparam int unsigned EX_MEM_CTRL_W = 32;
   localparam int unsigned MEM_WB_DATA_W = 101;  // load data, alu result, PC+4, rd
   localparam int unsigned MEM_WB_CTRL_W = 32;

   // Identifies which pipeline boundary an instance sits on
   typedef enum logic [1:0] {
      STAGE_IF_ID  = 2'd0,
      STAGE_ID_EX  = 2'd1,
      STAGE_EX_MEM = 2'd2,
      STAGE_MEM_WB = 2'd3
   } stage_e;

   // True when a control word would change architectural state
   function automatic logic ctrl_has_side_effect(input logic [DEF_CTRL_W-1:0] ctrl);
      return ctrl[CTRL_REG_WE] | ctrl[CTRL_MEM_WE] | ctrl[CTRL_JAL] |
             ctrl[CTRL_SYSCALL] | ctrl[CTRL_BRANCH_EQ] | ctrl[CTRL_BRANCH_NE] |
             ctrl[CTRL_JUMP] | ctrl[CTRL_JUMP_REG];
   endfunction

   // Even parity over a control word, for stages that carry a check bit
   function automatic logic ctrl_parity(input logic [DEF_CTRL_W-1:0] ctrl);
      return ^ctrl;
   endfunction

endpackage

// File: rtl/pipe_entry.sv
// One pipeline slot: valid, control and data registers.
// clear drops the slot to a bubble (valid and control zero, data untouched);
// load captures a new entry; otherwise the slot holds.
module pipe_entry
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned CTRL_W = DEF_CTRL_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear,
   input  logic [CTRL_W-1:0] ld_ctrl,
   input  logic [DATA_W-1:0] ld_data,
   output logic              valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] data
);

   logic              valid_r;
   logic [CTRL_W-1:0] ctrl_r;
   logic [DATA_W-1:0] data_r;

   // Valid and control: reset, bubble on clear, capture on load
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_r <= 1'b0;
         ctrl_r  <= {CTRL_W{1'b0}};
      end else if (clear) begin
         valid_r <= 1'b0;
         ctrl_r  <= {CTRL_W{1'b0}};
      end else if (load) begin
         valid_r <= 1'b1;
         ctrl_r  <= ld_ctrl;
      end else begin
         valid_r <= valid_r;
         ctrl_r  <= ctrl_r;
      end
   end

   // Data: only reset and load change it, a bubble keeps the stale payload
   always_ff @(posedge clk) begin
      if (!rst) begin
         data_r <= {DATA_W{1'b0}};
      end else if (clear) begin
         data_r <= data_r;
      end else if (load) begin
         data_r <= ld_data;
      end else begin
         data_r <= data_r;
      end
   end

   assign valid = valid_r;
   assign ctrl  = ctrl_r;
   assign data  = data_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable inter-stage pipeline register with valid/ready handshake,
// optional skid entry for full throughput under back-pressure, synchronous
// flush that inserts a bubble, and a saturating stall-cycle counter.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned CTRL_W = DEF_CTRL_W,
   parameter int unsigned SKID   = 1,
   parameter int unsigned CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Main entry (drives the outputs)
   logic              main_valid_s;
   logic [CTRL_W-1:0] main_ctrl_s;
   logic [DATA_W-1:0] main_data_s;
   logic              main_load_s;
   logic              main_clear_s;
   logic [CTRL_W-1:0] main_ld_ctrl_s;
   logic [DATA_W-1:0] main_ld_data_s;

   // Skid entry (constant empty when SKID=0)
   logic              skid_valid_s;
   logic [CTRL_W-1:0] skid_ctrl_s;
   logic [DATA_W-1:0] skid_data_s;

   // Handshake
   logic              in_ready_s;
   logic              accept_s;
   logic              consume_s;

   logic [CNT_W-1:0]  stall_cnt_r;

   // Handshake qualifiers; a flushed cycle never accepts
   always_comb begin
      accept_s  = in_valid & in_ready_s & ~flush;
      consume_s = main_valid_s & out_ready;
   end

   // Main entry next-state selection in priority order
   always_comb begin
      main_load_s    = 1'b0;
      main_clear_s   = 1'b0;
      main_ld_ctrl_s = in_ctrl;
      main_ld_data_s = in_data;
      if (flush) begin
         main_clear_s = 1'b1;
      end else if (consume_s && skid_valid_s) begin
         // Refill from the skid so the older entry leaves first
         main_load_s    = 1'b1;
         main_ld_ctrl_s = skid_ctrl_s;
         main_ld_data_s = skid_data_s;
      end else if (accept_s && (!main_valid_s || consume_s)) begin
         main_load_s = 1'b1;
      end else if (consume_s) begin
         // Drained with nothing behind it: present a bubble
         main_clear_s = 1'b1;
      end else begin
         main_load_s  = 1'b0;
         main_clear_s = 1'b0;
      end
   end

   pipe_entry #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
   ) u_main (
      .clk     (clk),
      .rst     (rst),
      .load    (main_load_s),
      .clear   (main_clear_s),
      .ld_ctrl (main_ld_ctrl_s),
      .ld_data (main_ld_data_s),
      .valid   (main_valid_s),
      .ctrl    (main_ctrl_s),
      .data    (main_data_s)
   );

   generate
      if (SKID != 32'd0) begin : g_skid
         logic skid_load_s;
         logic skid_clear_s;

         // Skid captures an accepted entry only while main is stalled;
         // it empties on flush or when main drains it
         always_comb begin
            in_ready_s   = ~skid_valid_s;
            skid_load_s  = accept_s & main_valid_s & ~out_ready;
            skid_clear_s = flush | (consume_s & skid_valid_s);
         end

         pipe_entry #(
            .DATA_W (DATA_W),
            .CTRL_W (CTRL_W)
         ) u_skid (
            .clk     (clk),
            .rst     (rst),
            .load    (skid_load_s),
            .clear   (skid_clear_s),
            .ld_ctrl (in_ctrl),
            .ld_data (in_data),
            .valid   (skid_valid_s),
            .ctrl    (skid_ctrl_s),
            .data    (skid_data_s)
         );
      end else begin : g_no_skid
         // Single entry: ready when empty or draining this cycle
         always_comb begin
            in_ready_s   = ~main_valid_s | out_ready;
            skid_valid_s = 1'b0;
            skid_ctrl_s  = {CTRL_W{1'b0}};
            skid_data_s  = {DATA_W{1'b0}};
         end
      end
   endgenerate

   // Saturating count of cycles where a valid output waits on downstream
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if (main_valid_s && !out_ready && (stall_cnt_r != CNT_MAX)) begin
         stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = main_valid_s;
   assign out_ctrl  = main_ctrl_s;
   assign out_data  = main_data_s;
   assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: three instances share the stimulus
// (skid mode, single-entry mode, skid mode with a 4-bit stall counter).
module tb_pipe_stage_reg;

   logic         clk;
   logic         rst;
   logic         flush;
   logic         in_valid;
   logic [159:0] in_data;
   logic [31:0]  in_ctrl;
   logic         out_ready;

   logic         s1_in_ready, s1_out_valid;
   logic [159:0] s1_out_data;
   logic [31:0]  s1_out_ctrl;
   logic [15:0]  s1_stall_cnt;

   logic         s0_in_ready, s0_out_valid;
   logic [159:0] s0_out_data;
   logic [31:0]  s0_out_ctrl;
   logic [15:0]  s0_stall_cnt;

   logic         st_in_ready, st_out_valid;
   logic [159:0] st_out_data;
   logic [31:0]  st_out_ctrl;
   logic [3:0]   st_stall_cnt;

   int tests_run = 0;
   int tests_failed = 0;

   pipe_stage_reg #(.DATA_W(160), .CTRL_W(32), .SKID(1), .CNT_W(16)) dut_s1 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s1_in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(s1_out_valid), .out_ready(out_ready),
      .out_data(s1_out_data), .out_ctrl(s1_out_ctrl), .stall_cnt(s1_stall_cnt));

   pipe_stage_reg #(.DATA_W(160), .CTRL_W(32), .SKID(0), .CNT_W(16)) dut_s0 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s0_in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(s0_out_valid), .out_ready(out_ready),
      .out_data(s0_out_data), .out_ctrl(s0_out_ctrl), .stall_cnt(s0_stall_cnt));

   pipe_stage_reg #(.DATA_W(160), .CTRL_W(32), .SKID(1), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(st_in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(st_out_valid), .out_ready(out_ready),
      .out_data(st_out_data), .out_ctrl(st_out_ctrl), .stall_cnt(st_stall_cnt));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      tests_run++;
      assert (obs === exp)
      else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] cv(input int d);
      return 32'hC0DE_0000 | 32'(d);
   endfunction

   task automatic offer(input int d);
      in_valid = 1'b1;
      in_data  = 160'(d);
      in_ctrl  = cv(d);
   endtask

   initial begin
      // Reset held two cycles with an all-ones control word offered
      rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
      in_valid = 1'b1; in_data = 160'hAA; in_ctrl = 32'hFFFF_FFFF;
      tick(); tick();
      chk("rst_out_valid", 160'(s1_out_valid), 160'd0);
      chk("rst_out_ctrl",  160'(s1_out_ctrl),  160'd0);
      chk("rst_out_data",  s1_out_data,        160'd0);
      chk("rst_stall_cnt", 160'(s1_stall_cnt), 160'd0);
      chk("rst_in_ready_s1", 160'(s1_in_ready), 160'd1);
      chk("rst_in_ready_s0", 160'(s0_in_ready), 160'd1);
      chk("rst_out_valid_s0", 160'(s0_out_valid), 160'd0);

      // Streaming 1..8 with out_ready=1, both modes, one cycle latency
      rst = 1'b1;
      for (int d = 1; d <= 8; d++) begin
         offer(d);
         tick();
         chk($sformatf("stream_s1_valid_%0d", d), 160'(s1_out_valid), 160'd1);
         chk($sformatf("stream_s1_data_%0d", d),  s1_out_data,        160'(d));
         chk($sformatf("stream_s1_ctrl_%0d", d),  160'(s1_out_ctrl),  160'(cv(d)));
         chk($sformatf("stream_s0_data_%0d", d),  s0_out_data,        160'(d));
         chk($sformatf("stream_s0_valid_%0d", d), 160'(s0_out_valid), 160'd1);
      end
      chk("stream_no_stall", 160'(s1_stall_cnt), 160'd0);

      // Stall with skid: out holds 1, entry 2 goes to skid
      offer(1); out_ready = 1'b1;
      tick();
      chk("stall_pre_data", s1_out_data, 160'd1);
      offer(2); out_ready = 1'b0;
      tick();
      chk("stall_hold_1", s1_out_data, 160'd1);
      chk("stall_in_ready_0", 160'(s1_in_ready), 160'd0);
      offer(3);
      tick(); tick();
      chk("stall_hold_3cyc", s1_out_data, 160'd1);
      chk("stall_cnt_3", 160'(s1_stall_cnt), 160'd3);
      chk("stall_in_ready_still_0", 160'(s1_in_ready), 160'd0);
      out_ready = 1'b1;
      tick();
      chk("release_out_2", s1_out_data, 160'd2);
      chk("release_ctrl_2", 160'(s1_out_ctrl), 160'(cv(2)));
      chk("release_in_ready", 160'(s1_in_ready), 160'd1);
      tick();
      chk("release_out_3", s1_out_data, 160'd3);
      chk("release_cnt_kept", 160'(s1_stall_cnt), 160'd3);

      // Counter saturation: 20 more stall cycles
      in_valid = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      chk("sat_cnt4_15", 160'(st_stall_cnt), 160'd15);
      chk("sat_cnt16_23", 160'(s1_stall_cnt), 160'd23);
      chk("sat_hold_3", s1_out_data, 160'd3);

      // Flush with main and skid full and entry 9 offered
      offer(4);
      tick();
      chk("flush_pre_skid_full", 160'(s1_in_ready), 160'd0);
      chk("flush_pre_cnt", 160'(s1_stall_cnt), 160'd24);
      offer(9); flush = 1'b1; out_ready = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_out_valid", 160'(s1_out_valid), 160'd0);
      chk("flush_out_ctrl",  160'(s1_out_ctrl),  160'd0);
      chk("flush_data_held", s1_out_data,        160'd3);
      chk("flush_in_ready",  160'(s1_in_ready),  160'd1);
      chk("flush_cnt_kept",  160'(s1_stall_cnt), 160'd24);
      chk("flush_sat_kept",  160'(st_stall_cnt), 160'd15);
      in_valid = 1'b0;
      tick();
      chk("flush_no_9", 160'(s1_out_valid), 160'd0);
      offer(10);
      tick();
      chk("post_flush_10", s1_out_data, 160'd10);
      chk("post_flush_valid", 160'(s1_out_valid), 160'd1);

      // Reset during a stall with skid full
      offer(11); out_ready = 1'b0;
      tick();
      chk("rst_stall_skid_full", 160'(s1_in_ready), 160'd0);
      chk("rst_stall_cnt_pre", 160'(s1_stall_cnt), 160'd25);
      rst = 1'b0;
      tick();
      chk("midrst_out_valid", 160'(s1_out_valid), 160'd0);
      chk("midrst_out_ctrl",  160'(s1_out_ctrl),  160'd0);
      chk("midrst_cnt",       160'(s1_stall_cnt), 160'd0);
      chk("midrst_sat_cnt",   160'(st_stall_cnt), 160'd0);
      chk("midrst_in_ready",  160'(s1_in_ready),  160'd1);
      rst = 1'b1; offer(12); out_ready = 1'b1;
      tick();
      chk("after_rst_12_s1", s1_out_data, 160'd12);
      chk("after_rst_12_s0", s0_out_data, 160'd12);
      chk("after_rst_valid", 160'(s1_out_valid), 160'd1);

      // Single-entry mode: in_ready follows out_ready combinationally
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      chk("s0_in_ready_blocked", 160'(s0_in_ready), 160'd0);
      out_ready = 1'b1;
      #1;
      chk("s0_in_ready_pass", 160'(s0_in_ready), 160'd1);
      tick();
      chk("drain_s1_valid", 160'(s1_out_valid), 160'd0);
      chk("drain_s1_ctrl",  160'(s1_out_ctrl),  160'd0);
      chk("drain_s0_valid", 160'(s0_out_valid), 160'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register that replaces the fixed, field-by-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with a single reusable block. It carries a datapath payload and a separately handled control payload behind a valid/ready handshake. It provides:
- an optional skid entry for full-throughput back-pressure;
- synchronous flush with bubble insertion, so squashed slots present all-zero control (no register write, no memory access, no branch);
- a saturating stall counter for performance analysis.

## Interface
Parameters:
- DATA_W, 160: datapath payload width (instruction, operands, immediate, PC+4); not cleared on bubble.
- CTRL_W, 32: control payload width; forced to zero whenever the slot is not valid.
- SKID, 1: 1 = two-entry skid buffer, registered in_ready; 0 = single entry, combinational in_ready.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- flush  in  1  squash every held and incoming entry this cycle.
- in_valid  in  1  upstream offers an entry.
- in_ready  out  1  block accepts an entry this cycle.
- in_data  in  DATA_W  datapath payload.
- in_ctrl  in  CTRL_W  control payload.
- out_valid  out  1  output entry is valid.
- out_ready  in  1  downstream consumes the output this cycle.
- out_data  out  DATA_W  registered datapath payload.
- out_ctrl  out  CTRL_W  registered control payload; 0 when out_valid=0.
- stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0.

## Operation
- Entries: main (drives out_*) and, when SKID=1, skid. Each entry holds valid, ctrl and data.
- Handshakes:
  - Accept = in_valid & in_ready & ~flush.
  - Consume = out_valid & out_ready.
- in_ready:
  - SKID=1: in_ready = ~skid_valid (registered state only).
  - SKID=0: in_ready = ~out_valid | out_ready.
- Main update, priority order:
  1. rst=0: clear everything.
  2. flush: main_valid, skid_valid and out_ctrl go to 0; data registers hold their values.
  3. Consume with skid_valid=1: main loads skid; skid_valid goes to 0.
  4. Accept with (~out_valid | Consume): main loads the input.
  5. Consume with no refill: main_valid goes to 0 and out_ctrl goes to 0.
  6. Otherwise: hold.
- Skid update (SKID=1 only): Accept with out_valid=1 and out_ready=0 loads skid. This case cannot coincide with skid_valid=1 because in_ready=0 then.
- Ordering: entries leave in acceptance order; no entry is ever duplicated or dropped, except by flush.
- stall_cnt:
  - Increments on cycles with out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset; flush does not clear it.
- Reset values: out_valid=0, out_ctrl=0, out_data=0, skid cleared, stall_cnt=0. in_ready after reset is 1 in both modes.

## Timing
- Latency: one cycle from accept to out_valid; zero-cycle hold when downstream is ready.
- Throughput: one entry per cycle under continuous out_ready=1 in both modes. With SKID=1, a single stall cycle is absorbed without deasserting in_ready on that cycle.
- Flush:
  - Effective the same cycle it is sampled; an input presented that cycle is discarded.
  - out_valid=0 on the next cycle.
  - in_ready on the next cycle: 1 in SKID=1 mode.
- Reset asserted mid-stall: all entries lost and the counter cleared at that edge. Reset has priority over flush and all handshakes.
- No combinational path from in_* to out_* in either mode. The only combinational path out_ready→in_ready exists when SKID=0.

## Structure
- Shared package pipe_pkg:
  - default widths;
  - control-bit index constants (REG_WE, MEM_WE, MEM_RD, JAL, SYSCALL, branch/jump bits);
  - per-stage CTRL_W/DATA_W constants, so every stage instance agrees on field layout.
- One sub-module, pipe_entry: valid/ctrl/data register with load, clear (zeroes valid and ctrl) and hold. It is instantiated as main and, under SKID=1, as skid.
- The counter and the handshake logic live in the top level.

## Test plan
- Reset: hold rst=0 for 2 cycles with in_valid=1, in_ctrl=0xFFFFFFFF → out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0. First edge after release with in_valid=1 → out_valid=1.
- Streaming: out_ready=1, send entries with data=1..8 on consecutive cycles → same sequence on out_data, one cycle later, no gaps; run in both SKID modes.
- Stall with skid (SKID=1): out holds 1, out_ready=0 for 3 cycles while entry 2 is offered → 2 is captured in skid and in_ready=0 on the next cycle. On release, out shows 2 then 3 with no loss; stall_cnt=3.
- Flush: flush=1 while main and skid are valid and in_valid=1 with entry 9 → next cycle out_valid=0, out_ctrl=0, entry 9 never appears, in_ready=1, stall_cnt unchanged.
- Counter saturation: CNT_W=4 with 20 stall cycles → stall_cnt=15.
- Reset during stall: skid full, rst=0 for one cycle → all valids 0, stall_cnt=0; the next accepted entry appears normally.
